// File: rtl/stream_width_upsizer.sv
`default_nettype none
// ============================================================================
// Module   : stream_width_upsizer
// Purpose  : Packs a narrow valid/ready sample stream into words RATIO lanes
//            wide. s_last closes a frame early, and the partial word is
//            flushed zero-padded with a per-lane keep mask. Completed words
//            leave through a registered valid/ready output stage. One extra
//            completed word can wait in the assembly register while the
//            output stage is stalled.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            s_valid/s_ready  - input handshake (s_ready is combinational)
//            s_data, s_last   - input sample and end-of-frame marker
//            m_valid/m_ready  - output handshake (m_valid is registered)
//            m_data           - packed word, lane 0 in the low bits
//            m_keep           - bit i set when lane i holds a real sample
//            m_last           - word ends a frame
// Revision : 1.0 - initial release
// ============================================================================
module stream_width_upsizer #(
    parameter int DATA_WIDTH = 16,
    parameter int RATIO      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH*RATIO-1:0] m_data,
    output logic [RATIO-1:0]            m_keep,
    output logic                        m_last
);

    localparam int              CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(RATIO - 1);

    // The state register doubles as the hold flag: HOLD means a completed
    // word sits in the assembly register waiting for the output stage.
    localparam logic [0:0] c_FILL = 1'b0;
    localparam logic [0:0] c_HOLD = 1'b1;

    logic [0:0]                  r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_last_flag;
    logic [RATIO-1:0]            r_hold_keep;
    logic [DATA_WIDTH-1:0]       r_lanes [RATIO];

    logic                        w_accept;
    logic                        w_complete;
    logic                        w_out_free;
    logic                        w_capture;
    logic                        w_load_new;
    logic                        w_load_held;
    logic [DATA_WIDTH*RATIO-1:0] w_word_data;
    logic [DATA_WIDTH*RATIO-1:0] w_held_data;
    logic [RATIO-1:0]            w_word_keep;

    assign s_ready     = (r_state == c_FILL) && !rst;
    assign w_accept    = s_valid && s_ready;
    assign w_complete  = w_accept && ((r_cnt == c_CNT_MAX) || s_last);
    assign w_out_free  = !m_valid || m_ready;
    assign w_load_new  = w_complete && w_out_free;
    assign w_capture   = w_complete && !w_out_free;
    assign w_load_held = (r_state == c_HOLD) && w_out_free;

    // Completed-word view: lanes below the counter come from storage, the
    // current lane from s_data, and anything above is forced to zero so a
    // short frame never leaks samples from an earlier word.
    for (genvar i = 0; i < RATIO; i++) begin : g_lane
        assign w_word_data[i*DATA_WIDTH +: DATA_WIDTH] =
            (CNT_W'(i) <  r_cnt) ? r_lanes[i] :
            (CNT_W'(i) == r_cnt) ? s_data     : '0;
        assign w_word_keep[i] = (CNT_W'(i) <= r_cnt);
        assign w_held_data[i*DATA_WIDTH +: DATA_WIDTH] = r_lanes[i];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_lanes[i] <= '0;
            end else if (w_capture) begin
                // Freeze the zero-padded word so HOLD can forward it verbatim.
                r_lanes[i] <= w_word_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (w_accept && (r_cnt == CNT_W'(i))) begin
                r_lanes[i] <= s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_FILL;
            r_cnt       <= '0;
            r_last_flag <= 1'b0;
            r_hold_keep <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_keep      <= '0;
            m_last      <= 1'b0;
        end else begin
            if (w_complete) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_capture) begin
                r_state     <= c_HOLD;
                r_hold_keep <= w_word_keep;
                r_last_flag <= s_last;
            end else if (w_load_held) begin
                r_state <= c_FILL;
            end

            // s_ready is low in HOLD, so a held load and a new completion
            // can never coincide.
            if (w_load_held) begin
                m_valid <= 1'b1;
                m_data  <= w_held_data;
                m_keep  <= r_hold_keep;
                m_last  <= r_last_flag;
            end else if (w_load_new) begin
                m_valid <= 1'b1;
                m_data  <= w_word_data;
                m_keep  <= w_word_keep;
                m_last  <= s_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_width_upsizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_width_upsizer
// Purpose  : Directed self-checking bench for stream_width_upsizer with
//            DATA_WIDTH=16, RATIO=4. Inputs change 1 time unit after the
//            rising edge; outputs are compared at that same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_width_upsizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;

    int total = 0;
    int bad   = 0;

    stream_width_upsizer #(.DATA_WIDTH(16), .RATIO(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_data  = 16'h0;
        s_last  = 1'b0;
    endtask

    int accepted;

    initial begin
        rst = 1'b1;
        m_ready = 1'b1;
        idle();
        tick();
        tick();
        // ---- reset state
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data",  m_data,       64'd0);
        check("rst_m_keep",  64'(m_keep),  64'd0);
        check("rst_m_last",  64'(m_last),  64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 64'(s_ready), 64'd1);

        // ---- continuous packing
        for (int k = 1; k <= 8; k++) begin
            drive(16'(k), k == 8);
            check("pack_s_ready", 64'(s_ready), 64'd1);
            tick();
            if (k == 4) begin
                check("pack_w1_valid", 64'(m_valid), 64'd1);
                check("pack_w1_data",  m_data, 64'h0004_0003_0002_0001);
                check("pack_w1_keep",  64'(m_keep), 64'hF);
                check("pack_w1_last",  64'(m_last), 64'd0);
            end
            if (k == 5) check("pack_gap_valid", 64'(m_valid), 64'd0);
            if (k == 8) begin
                check("pack_w2_valid", 64'(m_valid), 64'd1);
                check("pack_w2_data",  m_data, 64'h0008_0007_0006_0005);
                check("pack_w2_keep",  64'(m_keep), 64'hF);
                check("pack_w2_last",  64'(m_last), 64'd1);
            end
        end
        idle();
        tick();
        check("pack_drained", 64'(m_valid), 64'd0);

        // ---- partial flush
        drive(16'h000A, 1'b0); tick();
        drive(16'h000B, 1'b0); tick();
        drive(16'h000C, 1'b1); tick();
        check("part_valid", 64'(m_valid), 64'd1);
        check("part_data",  m_data, 64'h0000_000C_000B_000A);
        check("part_keep",  64'(m_keep), 64'h7);
        check("part_last",  64'(m_last), 64'd1);
        idle();
        tick();
        check("part_drained", 64'(m_valid), 64'd0);

        // ---- single-beat frame
        drive(16'h1234, 1'b1); tick();
        check("single_valid", 64'(m_valid), 64'd1);
        check("single_data",  m_data, 64'h0000_0000_0000_1234);
        check("single_keep",  64'(m_keep), 64'h1);
        check("single_last",  64'(m_last), 64'd1);
        idle();
        tick();

        // ---- backpressure: 12 offers with m_ready low
        m_ready  = 1'b0;
        accepted = 0;
        for (int c = 0; c < 12; c++) begin
            drive(16'h0100 + 16'(accepted + 1), 1'b0);
            #1;
            if (s_ready) accepted++;
            tick();
            if (c == 6) check("bp_mid_data", m_data, 64'h0104_0103_0102_0101);
        end
        check("bp_accepted", 64'(accepted), 64'd8);
        check("bp_s_ready",  64'(s_ready),  64'd0);
        check("bp_valid",    64'(m_valid),  64'd1);
        check("bp_hold_data", m_data, 64'h0104_0103_0102_0101);
        check("bp_hold_last", 64'(m_last), 64'd0);
        m_ready = 1'b1;
        tick();
        check("bp_w2_valid", 64'(m_valid), 64'd1);
        check("bp_w2_data",  m_data, 64'h0108_0107_0106_0105);
        check("bp_w2_keep",  64'(m_keep), 64'hF);
        check("bp_s_ready_back", 64'(s_ready), 64'd1);
        for (int k = 9; k <= 12; k++) begin
            drive(16'h0100 + 16'(k), 1'b0);
            tick();
        end
        check("bp_w3_valid", 64'(m_valid), 64'd1);
        check("bp_w3_data",  m_data, 64'h010C_010B_010A_0109);
        check("bp_w3_keep",  64'(m_keep), 64'hF);
        idle();
        tick();
        check("bp_drained", 64'(m_valid), 64'd0);

        // ---- reset mid-word
        drive(16'h0011, 1'b0); tick();
        drive(16'h0022, 1'b0); tick();
        idle();
        rst = 1'b1;
        tick();
        check("mid_rst_s_ready", 64'(s_ready), 64'd0);
        check("mid_rst_valid",   64'(m_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("mid_post_s_ready", 64'(s_ready), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            drive(16'h0030 + 16'(k), 1'b0);
            tick();
            if (k < 4) check("mid_no_valid", 64'(m_valid), 64'd0);
        end
        check("mid_valid", 64'(m_valid), 64'd1);
        check("mid_data",  m_data, 64'h0034_0033_0032_0031);
        check("mid_keep",  64'(m_keep), 64'hF);
        idle();
        tick();

        // ---- drain and complete in the same cycle
        m_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(16'h0040 + 16'(k), 1'b0);
            tick();
        end
        for (int k = 1; k <= 3; k++) begin
            drive(16'h0050 + 16'(k), 1'b0);
            tick();
        end
        check("dc_a_valid", 64'(m_valid), 64'd1);
        check("dc_a_data",  m_data, 64'h0044_0043_0042_0041);
        check("dc_s_ready", 64'(s_ready), 64'd1);
        drive(16'h0054, 1'b0);
        m_ready = 1'b1;
        tick();
        check("dc_b_valid", 64'(m_valid), 64'd1);
        check("dc_b_data",  m_data, 64'h0054_0053_0052_0051);
        check("dc_b_keep",  64'(m_keep), 64'hF);
        idle();
        tick();
        check("dc_drained", 64'(m_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
